// File: rtl/imgproc_pkg.sv
// imgproc_pkg: shared mode codes, FSM state encoding and arithmetic helpers
// for the 3x3-window image processor.
package imgproc_pkg;

  // Runtime processing modes
  localparam logic [1:0] MODE_COPY   = 2'd0;
  localparam logic [1:0] MODE_INVERT = 2'd1;
  localparam logic [1:0] MODE_MEAN   = 2'd2;
  localparam logic [1:0] MODE_MAX    = 2'd3;

  // Top-level sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Floor divide of the nine-pixel sum; callers pass a zero-extended DW+4-bit sum
  function automatic logic [31:0] div9(input logic [31:0] sum);
    return sum / 32'd9;
  endfunction

  // Largest of three values; callers zero-extend DW-bit pixels
  function automatic logic [31:0] max3(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/imgproc_linebuf.sv
// imgproc_linebuf: one image row worth of delay. Every enabled cycle shifts
// one pixel in; dout_o is the pixel that entered DEPTH shifts earlier.
module imgproc_linebuf #(
  parameter int DEPTH = 128,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift_en_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o
);

  logic [DW-1:0] line_q [DEPTH];

  // Row delay line, advanced only when a pixel is consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: this storage is a shift chain, not a RAM macro, so it can take
      // the async clear; the window logic relies on a clean start after reset.
      for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else if (shift_en_i) begin
      line_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign dout_o = line_q[DEPTH-1];

endmodule

// File: rtl/imgproc_win3.sv
// imgproc_win3: streams a raster image from the original-image memory through
// two line buffers into a 3x3 window and writes one processed pixel per centre
// to the result memory (COPY / INVERT / MEAN3x3 / MAX3x3), then raises finish.
// Optional build macro IMGPROC_THRESH_EN adds a thresh input that binarises
// every result after the mode function.
module imgproc_win3
  import imgproc_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int DW    = 8,
  parameter int AW    = $clog2(IMG_W*IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
`ifdef IMGPROC_THRESH_EN
  input  logic [DW-1:0] thresh,
`endif
  input  logic [DW-1:0] orig_data,
  input  logic          orig_ready,
  output logic          request,
  output logic [AW-1:0] orig_addr,
  output logic          imgproc_ready,
  output logic [AW-1:0] imgproc_addr,
  output logic [DW-1:0] imgproc_data,
  output logic          finish
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int SW   = DW + 4;

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] cen_q, cen_d;          // next centre index to be written
  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          finish_q, finish_d;

  // Window columns: a = oldest, b = middle (holds the centre), row 0 = top
  logic [DW-1:0] win_a_q [3];
  logic [DW-1:0] win_b_q [3];
  logic [DW-1:0] col_new [3];

  logic          accept, shift_en, emit, border;
  logic [DW-1:0] in_px, lb0_out, lb1_out, centre, res, out_px;
  logic [DW-1:0] row_max [3];
  logic [SW-1:0] sum;

  assign accept   = (state_q == READ) && orig_ready;
  assign shift_en = accept || (state_q == FLUSH);
  // Centre n resolves on accepting pixel n+IMG_W+1; flush resolves the tail
  assign emit     = (accept && (rd_addr_q >= AW'(IMG_W + 1))) || (state_q == FLUSH);
  assign in_px    = (state_q == READ) ? orig_data : '0;

  imgproc_linebuf #(.DEPTH(IMG_W), .DW(DW)) u_lb0 (
    .clk(clk), .rst(rst), .shift_en_i(shift_en), .din_i(in_px),   .dout_o(lb0_out)
  );
  imgproc_linebuf #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
    .clk(clk), .rst(rst), .shift_en_i(shift_en), .din_i(lb0_out), .dout_o(lb1_out)
  );

  // Sequencing and address/centre bookkeeping
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    mode_d    = mode_q;
    rd_addr_d = rd_addr_q;
    finish_d  = finish_q;
    cen_d     = cen_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    wr_d      = emit;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      IDLE: begin
        state_d   = READ;
        mode_d    = mode;
        rd_addr_d = '0;
      end
      READ: begin
        if (accept) begin
          if (rd_addr_q == AW'(NPIX - 1)) state_d = FLUSH;
          else                             rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      FLUSH: begin
        if (cen_q == AW'(NPIX - 1)) state_d = DONE;
      end
      DONE: begin
        finish_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      wr_addr_d = cen_q;
      wr_data_d = out_px;
      cen_d     = cen_q + 1'b1;
      if (cx_q == XW'(IMG_W - 1)) begin
        cx_d = '0;
        cy_d = cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  // Window pixel function on the post-shift window (columns a, b, new)
  always_comb begin
    col_new[0] = lb1_out;
    col_new[1] = lb0_out;
    col_new[2] = in_px;
    centre     = win_b_q[1];
    border     = (cx_q == '0) || (cx_q == XW'(IMG_W - 1)) ||
                 (cy_q == '0) || (cy_q == YW'(IMG_H - 1));
    sum        = '0;
    for (int r = 0; r < 3; r++) begin
      sum = sum + SW'(win_a_q[r]) + SW'(win_b_q[r]) + SW'(col_new[r]);
      row_max[r] = DW'(max3(32'(win_a_q[r]), 32'(win_b_q[r]), 32'(col_new[r])));
    end
    case (mode_q)
      MODE_COPY:   res = centre;
      MODE_INVERT: res = ~centre;
      MODE_MEAN:   res = border ? centre : DW'(div9(32'(sum)));
      MODE_MAX:    res = border ? centre
                                : DW'(max3(32'(row_max[0]), 32'(row_max[1]), 32'(row_max[2])));
      default:     res = centre;
    endcase
`ifdef IMGPROC_THRESH_EN
    out_px = (res >= thresh) ? '1 : '0;
`else
    out_px = res;
`endif
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_COPY;
      rd_addr_q <= '0;
      cen_q     <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      finish_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      state_q   <= state_d;
      mode_q    <= mode_d;
      rd_addr_q <= rd_addr_d;
      cen_q     <= cen_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      finish_q  <= finish_d;
    end
  end

  // Window column shift alongside the line buffers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++) begin
        win_a_q[r] <= '0;
        win_b_q[r] <= '0;
      end
    end else if (shift_en) begin
      for (int r = 0; r < 3; r++) begin
        win_a_q[r] <= win_b_q[r];
        win_b_q[r] <= col_new[r];
      end
    end
  end

  assign request       = (state_q == READ);
  assign orig_addr     = rd_addr_q;
  assign imgproc_ready = wr_q;
  assign imgproc_addr  = wr_addr_q;
  assign imgproc_data  = wr_data_q;
  assign finish        = finish_q;

endmodule

// File: tb/tb_imgproc_win3.sv
// tb_imgproc_win3: scoreboard bench. Stimulus pushes expected (addr, data)
// pairs; per-instance monitors pop and compare on every imgproc_ready.
module tb_imgproc_win3;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_px(input logic [7:0] v);
`ifdef IMGPROC_THRESH_EN
    return (v >= 8'h80) ? 8'hFF : 8'h00;
`else
    return v;
`endif
  endfunction

`ifdef IMGPROC_THRESH_EN
  logic [7:0] thresh_v = 8'h80;
`endif

  // ---------------- instance a: 4x4 ramp COPY ----------------
  logic       rst_a = 1'b0, ordy_a = 1'b1;
  logic [1:0] mode_a = 2'd0;
  logic [7:0] odata_a, wdata_a;
  logic [3:0] oaddr_a, waddr_a;
  logic       req_a, wr_a, fin_a;
  exp_t       q_a [$];
  assign odata_a = {4'h0, oaddr_a};

  imgproc_win3 #(.IMG_W(4), .IMG_H(4), .DW(8)) u_a (
    .clk(clk), .rst(rst_a), .mode(mode_a),
`ifdef IMGPROC_THRESH_EN
    .thresh(thresh_v),
`endif
    .orig_data(odata_a), .orig_ready(ordy_a), .request(req_a), .orig_addr(oaddr_a),
    .imgproc_ready(wr_a), .imgproc_addr(waddr_a), .imgproc_data(wdata_a), .finish(fin_a)
  );

  // ---------------- instance b: 5x5 MEAN then MAX ----------------
  logic       rst_b = 1'b0, ordy_b = 1'b1;
  logic [1:0] mode_b = 2'd0;
  logic [7:0] odata_b, wdata_b;
  logic [4:0] oaddr_b, waddr_b;
  logic       req_b, wr_b, fin_b;
  logic [7:0] img_b [25];
  exp_t       q_b [$];
  always_comb odata_b = (oaddr_b < 5'd25) ? img_b[oaddr_b] : 8'h00;

  imgproc_win3 #(.IMG_W(5), .IMG_H(5), .DW(8)) u_b (
    .clk(clk), .rst(rst_b), .mode(mode_b),
`ifdef IMGPROC_THRESH_EN
    .thresh(thresh_v),
`endif
    .orig_data(odata_b), .orig_ready(ordy_b), .request(req_b), .orig_addr(oaddr_b),
    .imgproc_ready(wr_b), .imgproc_addr(waddr_b), .imgproc_data(wdata_b), .finish(fin_b)
  );

  // ---------------- instance c: 8x8 MEAN, random stalls, mid-run reset ----------------
  logic       rst_c = 1'b0, ordy_c = 1'b1, rand_c = 1'b0;
  logic [1:0] mode_c = 2'd0;
  logic [7:0] odata_c, wdata_c;
  logic [5:0] oaddr_c, waddr_c;
  logic       req_c, wr_c, fin_c;
  logic [7:0] img_c [64];
  exp_t       q_c [$];
  always_comb odata_c = img_c[oaddr_c];

  imgproc_win3 #(.IMG_W(8), .IMG_H(8), .DW(8)) u_c (
    .clk(clk), .rst(rst_c), .mode(mode_c),
`ifdef IMGPROC_THRESH_EN
    .thresh(thresh_v),
`endif
    .orig_data(odata_c), .orig_ready(ordy_c), .request(req_c), .orig_addr(oaddr_c),
    .imgproc_ready(wr_c), .imgproc_addr(waddr_c), .imgproc_data(wdata_c), .finish(fin_c)
  );

  // ---------------- instance d: 128x128 INVERT ----------------
  logic        rst_d = 1'b0, ordy_d = 1'b1;
  logic [1:0]  mode_d = 2'd0;
  logic [7:0]  odata_d, wdata_d;
  logic [13:0] oaddr_d, waddr_d;
  logic        req_d, wr_d, fin_d;
  exp_t        q_d [$];
  assign odata_d = 8'h3C;

  imgproc_win3 #(.IMG_W(128), .IMG_H(128), .DW(8)) u_d (
    .clk(clk), .rst(rst_d), .mode(mode_d),
`ifdef IMGPROC_THRESH_EN
    .thresh(thresh_v),
`endif
    .orig_data(odata_d), .orig_ready(ordy_d), .request(req_d), .orig_addr(oaddr_d),
    .imgproc_ready(wr_d), .imgproc_addr(waddr_d), .imgproc_data(wdata_d), .finish(fin_d)
  );

  // Reference 3x3 mean for the 8x8 image, computed directly on the 2D raster
  function automatic logic [7:0] mean_ref_c(input int n);
    int x, y, s;
    x = n % 8;
    y = n / 8;
    s = 0;
    if (x == 0 || x == 7 || y == 0 || y == 7) return img_c[n];
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        s += int'(img_c[(y + dy) * 8 + x + dx]);
    return 8'(s / 9);
  endfunction

  // Random orig_ready for instance c, changed away from both clock edges
  initial forever begin
    @(posedge clk);
    #2;
    ordy_c = rand_c ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitors
  initial begin : mon_a
    exp_t e;
    logic wr_prev, fin_prev;
    wr_prev = 1'b0;
    fin_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        if (wr_a) begin
          check("a_write_expected", q_a.size() > 0, 1);
          if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("a_addr", waddr_a, e.addr);
            check("a_data", wdata_a, e.data);
          end
        end
        if (fin_a && !fin_prev) check("a_finish_after_last_write", wr_prev, 1);
        if (fin_a) check("a_finish_without_write", wr_a, 0);
      end
      wr_prev = wr_a;
      fin_prev = fin_a;
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_b && wr_b) begin
        check("b_write_expected", q_b.size() > 0, 1);
        if (q_b.size() > 0) begin
          e = q_b.pop_front();
          check("b_addr", waddr_b, e.addr);
          check("b_data", wdata_b, e.data);
        end
      end
      if (rst_b && fin_b) check("b_finish_without_write", wr_b, 0);
    end
  end

  initial begin : mon_c
    exp_t e;
    logic stall_prev;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_c && stall_prev) check("c_no_write_when_stalled", wr_c, 0);
      if (rst_c && wr_c) begin
        check("c_write_expected", q_c.size() > 0, 1);
        if (q_c.size() > 0) begin
          e = q_c.pop_front();
          check("c_addr", waddr_c, e.addr);
          check("c_data", wdata_c, e.data);
        end
      end
      stall_prev = rst_c && req_c && !ordy_c;
    end
  end

  initial begin : mon_d
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_d && wr_d) begin
        check("d_write_expected", q_d.size() > 0, 1);
        if (q_d.size() > 0) begin
          e = q_d.pop_front();
          check("d_addr", waddr_d, e.addr);
          check("d_data", wdata_d, e.data);
        end
      end
    end
  end

  // Stimulus
  initial begin : main
    exp_t e;
    logic [7:0] v;

    repeat (2) @(negedge clk);
    check("a_reset_outputs", {req_a, oaddr_a, wr_a, waddr_a, wdata_a, fin_a}, 0);

    // 4x4 COPY ramp
    for (int n = 0; n < 16; n++) begin
      e.addr = n;
      e.data = exp_px(8'(n));
      q_a.push_back(e);
    end
    mode_a = 2'd0;
    rst_a = 1'b1;
    for (int i = 0; i < 10 && !req_a; i++) @(negedge clk);
    check("a_request_up", req_a, 1);
    check("a_first_addr", oaddr_a, 0);
    for (int i = 0; i < 100 && !fin_a; i++) @(negedge clk);
    check("a_finish", fin_a, 1);
    check("a_all_written", q_a.size(), 0);
    repeat (3) @(negedge clk);
    check("a_finish_held", fin_a, 1);
    check("a_request_low_when_done", req_a, 0);

    // 128x128 INVERT of constant 0x3C
    for (int n = 0; n < 128 * 128; n++) begin
      e.addr = n;
      e.data = exp_px(8'hC3);
      q_d.push_back(e);
    end
    mode_d = 2'd1;
    rst_d = 1'b1;
    for (int i = 0; i < 20000 && !fin_d; i++) @(negedge clk);
    check("d_finish", fin_d, 1);
    check("d_all_written", q_d.size(), 0);

    // 5x5 MEAN of alternating 0/9
    for (int n = 0; n < 25; n++) img_b[n] = (n % 2 != 0) ? 8'd9 : 8'd0;
    for (int n = 0; n < 25; n++) begin
      if (n % 5 == 0 || n % 5 == 4 || n / 5 == 0 || n / 5 == 4) v = img_b[n];
      else v = (n % 2 != 0) ? 8'd5 : 8'd4;
      e.addr = n;
      e.data = exp_px(v);
      q_b.push_back(e);
    end
    mode_b = 2'd2;
    rst_b = 1'b1;
    for (int i = 0; i < 200 && !fin_b; i++) @(negedge clk);
    check("b_mean_finish", fin_b, 1);
    check("b_mean_all_written", q_b.size(), 0);

    // 5x5 MAX with a single 0xFF at index 12
    rst_b = 1'b0;
    for (int n = 0; n < 25; n++) img_b[n] = (n == 12) ? 8'hFF : 8'h10;
    for (int n = 0; n < 25; n++) begin
      case (n)
        6, 7, 8, 11, 12, 13, 16, 17, 18: v = 8'hFF;
        default:                         v = 8'h10;
      endcase
      e.addr = n;
      e.data = exp_px(v);
      q_b.push_back(e);
    end
    mode_b = 2'd3;
    @(negedge clk);
    check("b_reset_outputs", {req_b, oaddr_b, wr_b, waddr_b, wdata_b, fin_b}, 0);
    rst_b = 1'b1;
    for (int i = 0; i < 200 && !fin_b; i++) @(negedge clk);
    check("b_max_finish", fin_b, 1);
    check("b_max_all_written", q_b.size(), 0);

    // 8x8 MEAN with random stalls
    for (int n = 0; n < 64; n++) img_c[n] = 8'((n * 53 + 7 * (n / 8)) % 256);
    for (int n = 0; n < 64; n++) begin
      e.addr = n;
      e.data = exp_px(mean_ref_c(n));
      q_c.push_back(e);
    end
    mode_c = 2'd2;
    rand_c = 1'b1;
    rst_c = 1'b1;
    for (int i = 0; i < 2000 && !fin_c; i++) @(negedge clk);
    check("c_stall_finish", fin_c, 1);
    check("c_stall_all_written", q_c.size(), 0);

    // Reset mid-READ after 20 accepts, then a full rerun
    @(negedge clk);
    rst_c = 1'b0;
    for (int n = 0; n < 64; n++) img_c[n] = 8'((n * 29 + 100) % 256);
    for (int n = 0; n < 64; n++) begin
      e.addr = n;
      e.data = exp_px(mean_ref_c(n));
      q_c.push_back(e);
    end
    @(negedge clk);
    rst_c = 1'b1;
    for (int i = 0; i < 500 && oaddr_c != 6'd20; i++) @(negedge clk);
    check("c_reached_20_accepts", oaddr_c, 20);
    rst_c = 1'b0;
    #1;
    check("c_midrun_reset_outputs", {req_c, oaddr_c, wr_c, waddr_c, wdata_c, fin_c}, 0);
    q_c.delete();
    for (int n = 0; n < 64; n++) begin
      e.addr = n;
      e.data = exp_px(mean_ref_c(n));
      q_c.push_back(e);
    end
    @(negedge clk);
    rst_c = 1'b1;
    for (int i = 0; i < 10 && !req_c; i++) @(negedge clk);
    check("c_restart_request", req_c, 1);
    check("c_restart_addr", oaddr_c, 0);
    for (int i = 0; i < 2000 && !fin_c; i++) @(negedge clk);
    check("c_rerun_finish", fin_c, 1);
    check("c_rerun_all_written", q_c.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
